// File: rtl/raw_pack_32.sv
// raw_pack_32: packs PIXEL_WIDTH-bit raw pixels into 32-bit words, either two 16-bit lanes per word or as an LSB-first bitstream.
// Optional feature macro RAW_PACK_STATS_EN adds row_words, the PIXEL word count of the last completed row.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 8'h01
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 8'h02
`endif
`ifndef DTYPE_HEADER
`define DTYPE_HEADER 8'h04
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 8'h08
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 8'h10
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 8'h30
`endif
`ifndef Image_image_type
`define Image_image_type 2
`endif

module raw_pack_32 #(
    parameter int unsigned PIXEL_WIDTH    = 10,
    parameter int unsigned IMAGE_TYPE_POS = `Image_image_type
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [15:0]             datai,
    input  logic                    dvi,
    input  logic [`DTYPE_WIDTH-1:0] dtypei,
    input  logic [15:0]             image_type,
    input  logic                    pack,
    output logic [31:0]             datao,
    output logic                    dvo,
    output logic [`DTYPE_WIDTH-1:0] dtypeo,
`ifdef RAW_PACK_STATS_EN
    output logic [15:0]             row_words,
`endif
    output logic                    err
);

    localparam int unsigned     DW             = `DTYPE_WIDTH;
    localparam logic [15:0]     PIX_MASK       = 16'((32'd1 << PIXEL_WIDTH) - 32'd1);
    localparam logic [DW-1:0]   DT_PIXEL       = DW'(`DTYPE_PIXEL);
    localparam logic [DW-1:0]   DT_PIXEL_MASK  = DW'(`DTYPE_PIXEL_MASK);
    localparam logic [DW-1:0]   DT_HEADER      = DW'(`DTYPE_HEADER);
    localparam logic [DW-1:0]   DT_FRAME_START = DW'(`DTYPE_FRAME_START);
`ifdef RAW_PACK_STATS_EN
    localparam logic [DW-1:0]   DT_ROW_END     = DW'(`DTYPE_ROW_END);
`endif

    // ST_PENDING: a flush word went out last cycle and the terminating dtype is owed now
    typedef enum logic {
        ST_STREAM,
        ST_PENDING
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    acc_q, acc_d;
    logic [4:0]     n_q, n_d;
    logic           half_q, half_d;
    logic           half_hdr_q, half_hdr_d;
    logic [15:0]    lower_q, lower_d;
    logic [15:0]    hcnt_q, hcnt_d;
    logic [DW-1:0]  pend_q, pend_d;
    logic           mode_q, mode_d;
    logic           err_d;
    logic [31:0]    datao_d;
    logic [DW-1:0]  dtypeo_d;
    logic           dvo_d;
`ifdef RAW_PACK_STATS_EN
    logic [15:0]    wcnt_q, wcnt_d;
    logic [15:0]    row_words_d;
`endif

    logic [15:0]    pix;
    logic [47:0]    combined;
    logic [5:0]     n_sum;
    logic           is_pix;
    logic           is_hdr;
    logic [15:0]    hdr_val;
    logic           pair_en;
    logic [15:0]    pair_val;
    logic           pair_hdr;

    assign pix      = datai & PIX_MASK;
    assign combined = {16'd0, acc_q} | (48'(pix) << n_q);
    assign n_sum    = 6'(n_q) + 6'(PIXEL_WIDTH);
    assign is_pix   = |(dtypei & DT_PIXEL_MASK);
    assign is_hdr   = (dtypei == DT_HEADER);
    assign hdr_val  = (hcnt_q == 16'(IMAGE_TYPE_POS)) ? image_type : datai;

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        n_d        = n_q;
        half_d     = half_q;
        half_hdr_d = half_hdr_q;
        lower_d    = lower_q;
        hcnt_d     = hcnt_q;
        pend_d     = pend_q;
        mode_d     = mode_q;
        err_d      = err;
        datao_d    = datao;
        dtypeo_d   = dtypeo;
        dvo_d      = 1'b0;
        pair_en    = 1'b0;
        pair_val   = 16'd0;
        pair_hdr   = 1'b0;
`ifdef RAW_PACK_STATS_EN
        wcnt_d      = wcnt_q;
        row_words_d = row_words;
`endif

        case (state_q)
            ST_PENDING: begin
                dvo_d    = 1'b1;
                datao_d  = 32'd0;
                dtypeo_d = pend_q;
                state_d  = ST_STREAM;
                // A beat here breaks the blanking rule; it is dropped
                if (dvi) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                if (dvi) begin
                    if (is_pix) begin
                        hcnt_d = 16'd0;
                        if (mode_q) begin
                            if (n_sum >= 6'd32) begin
                                dvo_d    = 1'b1;
                                datao_d  = combined[31:0];
                                dtypeo_d = DT_PIXEL;
                                acc_d    = {16'd0, combined[47:32]};
                                n_d      = 5'(n_sum - 6'd32);
                            end else begin
                                acc_d = combined[31:0];
                                n_d   = n_sum[4:0];
                            end
                        end else begin
                            pair_en  = 1'b1;
                            pair_val = pix;
                        end
                    end else if (is_hdr) begin
                        hcnt_d   = (hcnt_q == 16'hFFFF) ? hcnt_q : hcnt_q + 16'd1;
                        pair_en  = 1'b1;
                        pair_val = hdr_val;
                        pair_hdr = 1'b1;
                    end else begin
                        hcnt_d = 16'd0;
                        if (dtypei == DT_FRAME_START) begin
                            mode_d = pack;
                        end
                        dvo_d = 1'b1;
                        if (n_q == 5'd0 && !half_q) begin
                            datao_d  = 32'd0;
                            dtypeo_d = dtypei;
                        end else begin
                            // Bits above the valid count are already zero in acc/lower
                            datao_d  = half_q ? {16'd0, lower_q} : acc_q;
                            dtypeo_d = (half_q && half_hdr_q) ? DT_HEADER : DT_PIXEL;
                            acc_d    = 32'd0;
                            n_d      = 5'd0;
                            half_d   = 1'b0;
                            pend_d   = dtypei;
                            state_d  = ST_PENDING;
                        end
                    end
                end
            end
        endcase

        // 16-bit lane pairing shared by unpacked pixels and header beats
        if (pair_en) begin
            if (half_q) begin
                dvo_d    = 1'b1;
                datao_d  = {pair_val, lower_q};
                dtypeo_d = pair_hdr ? DT_HEADER : DT_PIXEL;
                half_d   = 1'b0;
            end else begin
                lower_d    = pair_val;
                half_d     = 1'b1;
                half_hdr_d = pair_hdr;
            end
        end

`ifdef RAW_PACK_STATS_EN
        if (dvo_d && dtypeo_d == DT_ROW_END) begin
            row_words_d = wcnt_q;
            wcnt_d      = 16'd0;
        end else if (dvo_d && dtypeo_d == DT_PIXEL && wcnt_q != 16'hFFFF) begin
            wcnt_d = wcnt_q + 16'd1;
        end
`endif
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_STREAM;
            acc_q      <= 32'd0;
            n_q        <= 5'd0;
            half_q     <= 1'b0;
            half_hdr_q <= 1'b0;
            lower_q    <= 16'd0;
            hcnt_q     <= 16'd0;
            pend_q     <= '0;
            mode_q     <= 1'b0;
            err        <= 1'b0;
            datao      <= 32'd0;
            dtypeo     <= '0;
            dvo        <= 1'b0;
`ifdef RAW_PACK_STATS_EN
            wcnt_q     <= 16'd0;
            row_words  <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            n_q        <= n_d;
            half_q     <= half_d;
            half_hdr_q <= half_hdr_d;
            lower_q    <= lower_d;
            hcnt_q     <= hcnt_d;
            pend_q     <= pend_d;
            mode_q     <= mode_d;
            err        <= err_d;
            datao      <= datao_d;
            dtypeo     <= dtypeo_d;
            dvo        <= dvo_d;
`ifdef RAW_PACK_STATS_EN
            wcnt_q     <= wcnt_d;
            row_words  <= row_words_d;
`endif
        end
    end

endmodule

// File: tb/tb_raw_pack_32.sv
// tb_raw_pack_32: drives two raw_pack_32 instances (PIXEL_WIDTH 10 and 12) with shared stimulus and
// compares every cycle against a bit-queue reference model; RAW_PACK_STATS_EN also checks row_words.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 8'h01
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 8'h02
`endif
`ifndef DTYPE_HEADER
`define DTYPE_HEADER 8'h04
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 8'h08
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 8'h10
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 8'h30
`endif
`ifndef Image_image_type
`define Image_image_type 2
`endif

module tb_raw_pack_32;

    localparam logic [7:0] DT_FS  = 8'(`DTYPE_FRAME_START);
    localparam logic [7:0] DT_FE  = 8'(`DTYPE_FRAME_END);
    localparam logic [7:0] DT_HDR = 8'(`DTYPE_HEADER);
    localparam logic [7:0] DT_RE  = 8'(`DTYPE_ROW_END);
    localparam logic [7:0] DT_PIX = 8'(`DTYPE_PIXEL);
    localparam logic [7:0] DT_MSK = 8'(`DTYPE_PIXEL_MASK);
    localparam int         POS    = `Image_image_type;

    typedef struct packed {
        logic        dvo;
        logic [31:0] data;
        logic [7:0]  dtype;
        logic        err;
        logic [15:0] rw;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset, dvi, pack;
    logic [15:0] datai, image_type;
    logic [7:0]  dtypei;
    logic [31:0] datao10, datao12;
    logic        dvo10, dvo12, err10, err12;
    logic [7:0]  dtypeo10, dtypeo12;
`ifdef RAW_PACK_STATS_EN
    logic [15:0] rw10, rw12;
`endif

    int checks = 0;
    int failures = 0;

    rec_t exp0[$], exp1[$], act0[$], act1[$];

    always #5 clk = ~clk;

    raw_pack_32 #(.PIXEL_WIDTH(10)) u10 (
        .clk(clk), .reset(reset), .datai(datai), .dvi(dvi), .dtypei(dtypei),
        .image_type(image_type), .pack(pack), .datao(datao10), .dvo(dvo10), .dtypeo(dtypeo10),
`ifdef RAW_PACK_STATS_EN
        .row_words(rw10),
`endif
        .err(err10)
    );

    raw_pack_32 #(.PIXEL_WIDTH(12)) u12 (
        .clk(clk), .reset(reset), .datai(datai), .dvi(dvi), .dtypei(dtypei),
        .image_type(image_type), .pack(pack), .datao(datao12), .dvo(dvo12), .dtypeo(dtypeo12),
`ifdef RAW_PACK_STATS_EN
        .row_words(rw12),
`endif
        .err(err12)
    );

    // ---------------- reference model: bitstream as a queue of bits ----------------
    bit bq0[$];
    bit bq1[$];

    function automatic void bq_push(int k, bit b);
        if (k == 0) bq0.push_back(b); else bq1.push_back(b);
    endfunction
    function automatic bit bq_pop(int k);
        if (k == 0) return bq0.pop_front();
        return bq1.pop_front();
    endfunction
    function automatic int bq_size(int k);
        return (k == 0) ? bq0.size() : bq1.size();
    endfunction
    function automatic void bq_clear(int k);
        if (k == 0) bq0.delete(); else bq1.delete();
    endfunction

    logic        m_mode[2], m_pend_v[2], m_err[2], m_half_v[2], m_half_hdr[2];
    logic [7:0]  m_pend[2], m_dt[2];
    logic [31:0] m_data[2];
    logic [15:0] m_half[2], m_rw[2];
    int          m_hcnt[2], m_wcnt[2];

    task automatic model_step(input int k, input logic rst, input logic v, input logic [7:0] dt,
                              input logic [15:0] d, input logic pk, input logic [15:0] itype,
                              output rec_t e);
        int          pw;
        logic        emit;
        logic [31:0] w;
        logic [7:0]  wdt;
        logic [15:0] pix;
        logic [15:0] val;
        logic        is_h;
        pw   = (k == 0) ? 10 : 12;
        emit = 1'b0;
        w    = 32'd0;
        wdt  = 8'd0;
        pix  = d & 16'((32'd1 << pw) - 32'd1);
        if (rst) begin
            bq_clear(k);
            m_mode[k] = 0; m_pend_v[k] = 0; m_err[k] = 0; m_half_v[k] = 0; m_half_hdr[k] = 0;
            m_pend[k] = 0; m_dt[k] = 0; m_data[k] = 0; m_half[k] = 0; m_rw[k] = 0;
            m_hcnt[k] = 0; m_wcnt[k] = 0;
        end else if (m_pend_v[k]) begin
            emit = 1'b1; wdt = m_pend[k]; m_pend_v[k] = 1'b0;
            if (v) m_err[k] = 1'b1;
        end else if (v) begin
            if ((dt & DT_MSK) != 8'd0 || dt == DT_HDR) begin
                is_h = ((dt & DT_MSK) == 8'd0);
                val  = is_h ? ((m_hcnt[k] == POS) ? itype : d) : pix;
                m_hcnt[k] = is_h ? m_hcnt[k] + 1 : 0;
                if (!is_h && m_mode[k]) begin
                    for (int b = 0; b < pw; b++) bq_push(k, pix[b]);
                    if (bq_size(k) >= 32) begin
                        for (int j = 0; j < 32; j++) w[j] = bq_pop(k);
                        emit = 1'b1; wdt = DT_PIX;
                    end
                end else if (m_half_v[k]) begin
                    emit = 1'b1; w = {val, m_half[k]}; wdt = is_h ? DT_HDR : DT_PIX;
                    m_half_v[k] = 1'b0;
                end else begin
                    m_half_v[k] = 1'b1; m_half[k] = val; m_half_hdr[k] = is_h;
                end
            end else begin
                m_hcnt[k] = 0;
                if (dt == DT_FS) m_mode[k] = pk;
                emit = 1'b1;
                if (!m_half_v[k] && bq_size(k) == 0) begin
                    wdt = dt;
                end else begin
                    if (m_half_v[k]) begin
                        w = {16'd0, m_half[k]}; wdt = m_half_hdr[k] ? DT_HDR : DT_PIX;
                    end else begin
                        for (int j = 0; bq_size(k) > 0; j++) w[j] = bq_pop(k);
                        wdt = DT_PIX;
                    end
                    m_half_v[k] = 1'b0; m_pend_v[k] = 1'b1; m_pend[k] = dt;
                end
            end
        end
        if (emit) begin
            m_data[k] = w; m_dt[k] = wdt;
            if (wdt == DT_RE) begin
                m_rw[k] = 16'(m_wcnt[k]); m_wcnt[k] = 0;
            end else if (wdt == DT_PIX && m_wcnt[k] < 65535) begin
                m_wcnt[k] = m_wcnt[k] + 1;
            end
        end
        e.dvo = emit; e.data = m_data[k]; e.dtype = m_dt[k]; e.err = m_err[k];
`ifdef RAW_PACK_STATS_EN
        e.rw = m_rw[k];
`else
        e.rw = 16'd0;
`endif
    endtask

    // One clock: apply inputs, advance the model, capture DUT outputs #1 after the edge
    task automatic cyc(input logic rst, input logic v, input logic [7:0] dt, input logic [15:0] d,
                       input logic pk);
        rec_t e0, e1, a0, a1;
        reset = rst; dvi = v; dtypei = dt; datai = d; pack = pk;
        model_step(0, rst, v, dt, d, pk, image_type, e0);
        model_step(1, rst, v, dt, d, pk, image_type, e1);
        @(posedge clk);
        #1;
        a0.dvo = dvo10; a0.data = datao10; a0.dtype = dtypeo10; a0.err = err10;
        a1.dvo = dvo12; a1.data = datao12; a1.dtype = dtypeo12; a1.err = err12;
`ifdef RAW_PACK_STATS_EN
        a0.rw = rw10; a1.rw = rw12;
`else
        a0.rw = 16'd0; a1.rw = 16'd0;
`endif
        exp0.push_back(e0); exp1.push_back(e1); act0.push_back(a0); act1.push_back(a1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'd0, 16'd0, 1'b0);
    endtask

    function automatic void clear_q();
        exp0.delete(); exp1.delete(); act0.delete(); act1.delete();
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_q();
        cyc(1'b1, 1'b1, DT_PIX, 16'h0123, 1'b1);
        cyc(1'b1, 1'b0, 8'd0, 16'd0, 1'b0);
        idle(2);
        for (int i = 0; i < exp0.size(); i++) begin
            checks++;
            if (act0[i] !== exp0[i]) begin failures++; $display("FAIL reset pw10 cyc %0d: got %h want %h", i, act0[i], exp0[i]); end
            checks++;
            if (act1[i] !== exp1[i]) begin failures++; $display("FAIL reset pw12 cyc %0d: got %h want %h", i, act1[i], exp1[i]); end
        end
        checks++;
        if ({dvo10, datao10, dtypeo10, err10} !== 42'd0) begin
            failures++; $display("FAIL reset_zero: got dvo=%b data=%h dt=%h err=%b want all 0", dvo10, datao10, dtypeo10, err10);
        end
    endtask

    task automatic test_packed();
        clear_q();
        cyc(1'b0, 1'b1, DT_FS, 16'd0, 1'b1);
        idle(1);
        for (int i = 1; i <= 16; i++) cyc(1'b0, 1'b1, DT_PIX, 16'(i), 1'b0);
        cyc(1'b0, 1'b1, DT_RE, 16'd0, 1'b0);
        idle(2);
        for (int i = 0; i < exp0.size(); i++) begin
            checks++;
            if (act0[i] !== exp0[i]) begin failures++; $display("FAIL packed pw10 cyc %0d: got %h want %h", i, act0[i], exp0[i]); end
            checks++;
            if (act1[i] !== exp1[i]) begin failures++; $display("FAIL packed pw12 cyc %0d: got %h want %h", i, act1[i], exp1[i]); end
        end
        checks++;
        if (act0[5].data !== 32'h00300801 || act0[5].dvo !== 1'b1) begin
            failures++; $display("FAIL packed_first_word: got %h want 00300801", act0[5].data);
        end
        checks++;
        if (act0[17].dtype !== DT_PIX || act0[18].dtype !== DT_RE || act0[18].data !== 32'd0 || act0[18].dvo !== 1'b1) begin
            failures++; $display("FAIL packed_row_end_timing: got dt17=%h dt18=%h d18=%h want %h %h 0", act0[17].dtype, act0[18].dtype, act0[18].data, DT_PIX, DT_RE);
        end
`ifdef RAW_PACK_STATS_EN
        checks++;
        if (act0[18].rw !== 16'd5 || act1[18].rw !== 16'd6) begin
            failures++; $display("FAIL row_words: got %0d/%0d want 5/6", act0[18].rw, act1[18].rw);
        end
`endif
    endtask

    task automatic test_unpacked();
        clear_q();
        cyc(1'b0, 1'b1, DT_FS, 16'd0, 1'b0);
        idle(1);
        cyc(1'b0, 1'b1, DT_PIX, 16'h0AAA, 1'b0);
        cyc(1'b0, 1'b1, DT_PIX, 16'h0BBB, 1'b0);
        cyc(1'b0, 1'b1, DT_PIX, 16'h0CCC, 1'b0);
        cyc(1'b0, 1'b1, DT_RE, 16'd0, 1'b0);
        idle(2);
        for (int i = 0; i < exp0.size(); i++) begin
            checks++;
            if (act0[i] !== exp0[i]) begin failures++; $display("FAIL unpacked pw10 cyc %0d: got %h want %h", i, act0[i], exp0[i]); end
            checks++;
            if (act1[i] !== exp1[i]) begin failures++; $display("FAIL unpacked pw12 cyc %0d: got %h want %h", i, act1[i], exp1[i]); end
        end
        checks++;
        if (act1[3].data !== 32'h0BBB0AAA || act1[5].data !== 32'h00000CCC || act1[5].dtype !== DT_PIX
            || act1[6].dtype !== DT_RE || act1[6].data !== 32'd0) begin
            failures++; $display("FAIL unpacked_words: got %h %h/%h %h/%h want 0bbb0aaa 00000ccc/%h 0/%h",
                                 act1[3].data, act1[5].data, act1[5].dtype, act1[6].data, act1[6].dtype, DT_PIX, DT_RE);
        end
    endtask

    task automatic test_packed12();
        clear_q();
        cyc(1'b0, 1'b1, DT_FS, 16'd0, 1'b1);
        idle(1);
        cyc(1'b0, 1'b1, DT_PIX, 16'h0FFF, 1'b0);
        cyc(1'b0, 1'b1, DT_PIX, 16'h0001, 1'b0);
        cyc(1'b0, 1'b1, DT_PIX, 16'h0ABC, 1'b0);
        cyc(1'b0, 1'b1, DT_RE, 16'd0, 1'b0);
        idle(2);
        for (int i = 0; i < exp0.size(); i++) begin
            checks++;
            if (act0[i] !== exp0[i]) begin failures++; $display("FAIL packed12 pw10 cyc %0d: got %h want %h", i, act0[i], exp0[i]); end
            checks++;
            if (act1[i] !== exp1[i]) begin failures++; $display("FAIL packed12 pw12 cyc %0d: got %h want %h", i, act1[i], exp1[i]); end
        end
        checks++;
        if (act1[4].data !== 32'hBC001FFF || act1[5].data !== 32'h0000000A || act1[6].dtype !== DT_RE) begin
            failures++; $display("FAIL packed12_words: got %h %h dt=%h want bc001fff 0000000a dt=%h", act1[4].data, act1[5].data, act1[6].dtype, DT_RE);
        end
    endtask

    task automatic test_header();
        logic [31:0] ew[6];
        logic [7:0]  et[6];
        int          n;
        ew = '{32'd0, 32'h10011000, 32'h1003BEEF, 32'h10051004, 32'h00001006, 32'd0};
        et = '{DT_FS, DT_HDR, DT_HDR, DT_HDR, DT_HDR, DT_FE};
        clear_q();
        image_type = 16'hBEEF;
        cyc(1'b0, 1'b1, DT_FS, 16'd0, 1'b0);
        idle(1);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, DT_HDR, 16'(16'h1000 + i), 1'b0);
        cyc(1'b0, 1'b1, DT_FE, 16'd0, 1'b0);
        idle(2);
        n = 0;
        for (int i = 0; i < exp0.size(); i++) begin
            checks++;
            if (act0[i] !== exp0[i]) begin failures++; $display("FAIL header pw10 cyc %0d: got %h want %h", i, act0[i], exp0[i]); end
            checks++;
            if (act1[i] !== exp1[i]) begin failures++; $display("FAIL header pw12 cyc %0d: got %h want %h", i, act1[i], exp1[i]); end
            if (act0[i].dvo === 1'b1 && n < 6) begin
                checks++;
                if (act0[i].data !== ew[n] || act0[i].dtype !== et[n]) begin
                    failures++; $display("FAIL header_word %0d: got %h/%h want %h/%h", n, act0[i].data, act0[i].dtype, ew[n], et[n]);
                end
                n++;
            end
        end
        checks++;
        if (n != 6) begin failures++; $display("FAIL header_count: got %0d want 6", n); end
    endtask

    task automatic test_reset_midrow();
        clear_q();
        cyc(1'b0, 1'b1, DT_FS, 16'd0, 1'b1);
        idle(1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, DT_PIX, 16'h03FF, 1'b0);
        cyc(1'b1, 1'b1, DT_PIX, 16'h03FF, 1'b0);
        cyc(1'b0, 1'b1, DT_FS, 16'd0, 1'b1);
        idle(1);
        for (int i = 1; i <= 16; i++) cyc(1'b0, 1'b1, DT_PIX, 16'(i), 1'b0);
        cyc(1'b0, 1'b1, DT_RE, 16'd0, 1'b0);
        idle(2);
        for (int i = 0; i < exp0.size(); i++) begin
            checks++;
            if (act0[i] !== exp0[i]) begin failures++; $display("FAIL reset_midrow pw10 cyc %0d: got %h want %h", i, act0[i], exp0[i]); end
            checks++;
            if (act1[i] !== exp1[i]) begin failures++; $display("FAIL reset_midrow pw12 cyc %0d: got %h want %h", i, act1[i], exp1[i]); end
        end
        checks++;
        if (act0[5] !== rec_t'(0) || act0[12].data !== 32'h00300801) begin
            failures++; $display("FAIL reset_midrow_clean: got %h / %h want 0 / 00300801", act0[5], act0[12].data);
        end
    endtask

    task automatic test_random();
        logic [7:0] pdt;
        clear_q();
        for (int f = 0; f < 4; f++) begin
            image_type = 16'($urandom);
            cyc(1'b0, 1'b1, DT_FS, 16'($urandom), 1'($urandom));
            idle(1);
            for (int h = 0; h < int'($urandom_range(0, 7)); h++) cyc(1'b0, 1'b1, DT_HDR, 16'($urandom), 1'b0);
            cyc(1'b0, 1'b1, DT_RE, 16'd0, 1'b0);
            idle($urandom_range(1, 2));
            for (int r = 0; r < 3; r++) begin
                for (int p = 0; p < int'($urandom_range(1, 40)); p++) begin
                    pdt = ($urandom_range(0, 1) == 0) ? DT_PIX : 8'h20;
                    cyc(1'b0, 1'b1, pdt, 16'($urandom), 1'b0);
                    if ($urandom_range(0, 4) == 0) idle(1);
                end
                cyc(1'b0, 1'b1, DT_RE, 16'd0, 1'b0);
                idle($urandom_range(1, 2));
            end
            cyc(1'b0, 1'b1, DT_FE, 16'd0, 1'b0);
            idle(1);
        end
        for (int i = 0; i < exp0.size(); i++) begin
            checks++;
            if (act0[i] !== exp0[i]) begin failures++; $display("FAIL random pw10 cyc %0d: got %h want %h", i, act0[i], exp0[i]); end
            checks++;
            if (act1[i] !== exp1[i]) begin failures++; $display("FAIL random pw12 cyc %0d: got %h want %h", i, act1[i], exp1[i]); end
        end
    endtask

    task automatic test_protocol_err();
        clear_q();
        cyc(1'b0, 1'b1, DT_FS, 16'd0, 1'b1);
        idle(1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, DT_PIX, 16'(16'h0100 + i), 1'b0);
        cyc(1'b0, 1'b1, DT_RE, 16'd0, 1'b0);
        cyc(1'b0, 1'b1, DT_PIX, 16'h0055, 1'b0);
        idle(3);
        cyc(1'b1, 1'b0, 8'd0, 16'd0, 1'b0);
        idle(1);
        for (int i = 0; i < exp0.size(); i++) begin
            checks++;
            if (act0[i] !== exp0[i]) begin failures++; $display("FAIL protocol pw10 cyc %0d: got %h want %h", i, act0[i], exp0[i]); end
            checks++;
            if (act1[i] !== exp1[i]) begin failures++; $display("FAIL protocol pw12 cyc %0d: got %h want %h", i, act1[i], exp1[i]); end
        end
        checks++;
        if (act0[6].dtype !== DT_RE || act0[6].err !== 1'b1 || act0[9].err !== 1'b1 || act0[11].err !== 1'b0) begin
            failures++; $display("FAIL protocol_err: got dt6=%h err6=%b err9=%b err11=%b want %h 1 1 0",
                                 act0[6].dtype, act0[6].err, act0[9].err, act0[11].err, DT_RE);
        end
    endtask

    initial begin
        reset = 1'b1; dvi = 1'b0; dtypei = 8'd0; datai = 16'd0; pack = 1'b0; image_type = 16'hBEEF;
        test_reset();
        test_packed();
        test_unpacked();
        test_packed12();
        test_header();
        test_reset_midrow();
        test_random();
        test_protocol_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
